mem_data_lsu: RTL and testbench

//  Parametrised data memory with a load/store front end for the MEM stage of the MIPS pipeline.

---
 rtl/mem_data_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_mem_data_lsu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_lsu.sv
// mem_data_lsu: byte-addressable little-endian data memory for the MEM stage.
// Load/store front end with sign/zero extension, misalignment detection,
// a post-reset clear sequence and a registered word-wide debug read port.
module mem_data_lsu #(
    parameter int NB_DATA      = 32,
    parameter int NB_ADDR      = 7,
    parameter int READ_LATENCY = 1,
    parameter int NB_DBG_ADDR  = NB_ADDR - 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_mem_write_flag,
    input  logic                   i_mem_read_flag,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [NB_ADDR-1:0]     i_addr,
    input  logic [NB_DATA-1:0]     i_write_data,
    input  logic [NB_DBG_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0]     o_read_data,
    output logic                   o_read_valid,
    output logic                   o_misaligned,
    output logic                   o_busy,
    output logic [NB_DATA-1:0]     o_dbg_data
);

    localparam int                  DEPTH     = 2 ** NB_ADDR;
    localparam int                  NB_WADDR  = NB_ADDR - 2;
    localparam logic [NB_WADDR-1:0] LAST_WORD = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [NB_WADDR-1:0]   r_clr_cnt;
    logic [NB_WADDR-1:0]   w_clr_cnt_next;
    logic                  w_busy;

    logic [7:0]            r_mem [DEPTH];

    logic                  w_active;
    logic                  w_aligned;
    logic                  w_st_ok;
    logic                  w_st_bad;
    logic                  w_ld_ok;
    logic                  w_ld_bad;
    logic [NB_ADDR-1:0]    w_a1;
    logic [NB_ADDR-1:0]    w_a2;
    logic [NB_ADDR-1:0]    w_a3;
    logic [NB_DATA-1:0]    w_ld_word;

    logic                  r_vld_p1;
    logic                  r_ld_mis_p1;
    logic                  r_st_mis_p1;
    logic [NB_DATA-1:0]    r_data_p1;
    logic                  w_ld_mis_out;
    logic [NB_DATA-1:0]    r_dbg_data;

    // Byte/half results are extended to the full word; word loads pass through.
    function automatic logic [NB_DATA-1:0] f_extend(
        input logic [NB_DATA-1:0] word,
        input logic [1:0]         size,
        input logic               uns
    );
        case (size)
            2'b00:   f_extend = uns ? {24'd0, word[7:0]}  : {{24{word[7]}},  word[7:0]};
            2'b01:   f_extend = uns ? {16'd0, word[15:0]} : {{16{word[15]}}, word[15:0]};
            default: f_extend = word;
        endcase
    endfunction

    // State and clear-counter register; reset restarts the clear from word 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Next-state logic: walk every word once, then serve requests forever.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_busy         = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy         = 1'b1;
                w_clr_cnt_next = r_clr_cnt + NB_WADDR'(1);
                if (r_clr_cnt == LAST_WORD) begin
                    w_state_next = ST_READY;
                end
            end
            default: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    assign o_busy = w_busy;

    // Request decode: a store wins when both flags are set.
    always_comb begin
        case (i_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~i_addr[0];
            2'b10:   w_aligned = (i_addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_active = ~i_reset & (r_state == ST_READY);
    assign w_st_ok  = w_active & i_mem_write_flag & w_aligned;
    assign w_st_bad = w_active & i_mem_write_flag & ~w_aligned;
    assign w_ld_ok  = w_active & i_mem_read_flag & ~i_mem_write_flag & w_aligned;
    assign w_ld_bad = w_active & i_mem_read_flag & ~i_mem_write_flag & ~w_aligned;

    assign w_a1 = i_addr + NB_ADDR'(1);
    assign w_a2 = i_addr + NB_ADDR'(2);
    assign w_a3 = i_addr + NB_ADDR'(3);
    assign w_ld_word = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[i_addr]};

    // Storage: clear one word per cycle while clearing, else apply aligned stores.
    always_ff @(posedge i_clock) begin
        if (!i_reset && r_state == ST_CLEAR) begin
            r_mem[{r_clr_cnt, 2'b00}] <= 8'd0;
            r_mem[{r_clr_cnt, 2'b01}] <= 8'd0;
            r_mem[{r_clr_cnt, 2'b10}] <= 8'd0;
            r_mem[{r_clr_cnt, 2'b11}] <= 8'd0;
        end else if (w_st_ok) begin
            r_mem[i_addr] <= i_write_data[7:0];
            if (i_size != 2'b00) begin
                r_mem[w_a1] <= i_write_data[15:8];
            end
            if (i_size == 2'b10) begin
                r_mem[w_a2] <= i_write_data[23:16];
                r_mem[w_a3] <= i_write_data[31:24];
            end
        end
    end

    // Stage p1: sample and extend load data at the request edge; flag drops.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vld_p1    <= 1'b0;
            r_ld_mis_p1 <= 1'b0;
            r_st_mis_p1 <= 1'b0;
            r_data_p1   <= '0;
        end else begin
            r_vld_p1    <= w_ld_ok;
            r_ld_mis_p1 <= w_ld_bad;
            r_st_mis_p1 <= w_st_bad;
            if (w_ld_ok) begin
                r_data_p1 <= f_extend(w_ld_word, i_size, i_unsigned);
            end
        end
    end

    // Any latency other than 2 builds the single-stage path.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic               r_vld_p2;
            logic               r_ld_mis_p2;
            logic [NB_DATA-1:0] r_data_p2;

            // Stage p2: extra output register; data holds between results.
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_vld_p2    <= 1'b0;
                    r_ld_mis_p2 <= 1'b0;
                    r_data_p2   <= '0;
                end else begin
                    r_vld_p2    <= r_vld_p1;
                    r_ld_mis_p2 <= r_ld_mis_p1;
                    if (r_vld_p1) begin
                        r_data_p2 <= r_data_p1;
                    end
                end
            end

            assign o_read_valid = r_vld_p2;
            assign o_read_data  = r_data_p2;
            assign w_ld_mis_out = r_ld_mis_p2;
        end else begin : g_lat1
            assign o_read_valid = r_vld_p1;
            assign o_read_data  = r_data_p1;
            assign w_ld_mis_out = r_ld_mis_p1;
        end
    endgenerate

    // A dropped load reports when its result would have; a dropped store one cycle later.
    assign o_misaligned = r_st_mis_p1 | w_ld_mis_out;

    // Debug port: registered word read, independent of FSM state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= {r_mem[{i_dbg_addr, 2'b11}], r_mem[{i_dbg_addr, 2'b10}],
                           r_mem[{i_dbg_addr, 2'b01}], r_mem[{i_dbg_addr, 2'b00}]};
        end
    end

    assign o_dbg_data = r_dbg_data;

endmodule

// File: tb/tb_mem_data_lsu.sv
// tb_mem_data_lsu: drives one latency-1 and one latency-2 instance with shared
// stimulus and compares both against a byte-array reference model every cycle.
module tb_mem_data_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic        uns;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  dbg_addr;

    logic [31:0] rd1, rd2, dbg1, dbg2;
    logic        vld1, vld2, mis1, mis2, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0]  ref_mem [128];
    int          clr_left  = 0;
    bit          mem_known = 0;
    logic        e_vld1, e_mis1, e_vld2, e_mis2, p2_vld, p2_mis, e_busy;
    logic [31:0] e_data1, e_data2, p2_data, e_dbg;

    always #5 clk = ~clk;

    mem_data_lsu #(.NB_DATA(32), .NB_ADDR(7), .READ_LATENCY(1), .NB_DBG_ADDR(5)) u_dut_l1 (
        .i_clock(clk), .i_reset(rst), .i_mem_write_flag(wr), .i_mem_read_flag(rd),
        .i_size(size), .i_unsigned(uns), .i_addr(addr), .i_write_data(wdata),
        .i_dbg_addr(dbg_addr), .o_read_data(rd1), .o_read_valid(vld1),
        .o_misaligned(mis1), .o_busy(busy1), .o_dbg_data(dbg1)
    );

    mem_data_lsu #(.NB_DATA(32), .NB_ADDR(7), .READ_LATENCY(2), .NB_DBG_ADDR(5)) u_dut_l2 (
        .i_clock(clk), .i_reset(rst), .i_mem_write_flag(wr), .i_mem_read_flag(rd),
        .i_size(size), .i_unsigned(uns), .i_addr(addr), .i_write_data(wdata),
        .i_dbg_addr(dbg_addr), .o_read_data(rd2), .o_read_valid(vld2),
        .o_misaligned(mis2), .o_busy(busy2), .o_dbg_data(dbg2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic tick();
        bit          legal, ld_ok, ld_bad, st_bad;
        int          nbytes, a;
        longint      v;
        logic [31:0] ldv;
        ld_ok = 0; ld_bad = 0; st_bad = 0; ldv = '0;
        if (rst) begin
            clr_left = 32;
            e_vld1 = 0; e_mis1 = 0; e_data1 = '0;
            e_vld2 = 0; e_mis2 = 0; e_data2 = '0;
            p2_vld = 0; p2_mis = 0; p2_data = '0;
            e_dbg  = '0;
        end else begin
            e_dbg = ref_word(int'(dbg_addr) * 4);
            if (clr_left > 0) begin
                for (int i = 0; i < 4; i++) ref_mem[(32 - clr_left) * 4 + i] = 8'h00;
                clr_left--;
                if (clr_left == 0) mem_known = 1;
            end else if (wr || rd) begin
                a      = int'(addr);
                nbytes = 1 << size;
                legal  = (size == 0) || (size == 1 && a % 2 == 0) || (size == 2 && a % 4 == 0);
                if (wr) begin
                    if (legal) begin
                        for (int i = 0; i < nbytes; i++) ref_mem[a+i] = wdata[8*i +: 8];
                    end else begin
                        st_bad = 1;
                    end
                end else if (legal) begin
                    v = 0;
                    for (int i = 0; i < nbytes; i++) v = v + (longint'(ref_mem[a+i]) << (8*i));
                    if (!uns && nbytes < 4 && ((v >> (8*nbytes - 1)) & 1) == 1)
                        v = v - (longint'(1) << (8*nbytes));
                    ldv   = v[31:0];
                    ld_ok = 1;
                end else begin
                    ld_bad = 1;
                end
            end
            e_vld1 = ld_ok;
            e_mis1 = ld_bad | st_bad;
            if (ld_ok) e_data1 = ldv;
            e_vld2 = p2_vld;
            e_mis2 = p2_mis | st_bad;
            if (p2_vld) e_data2 = p2_data;
            p2_vld = ld_ok;
            p2_mis = ld_bad;
            if (ld_ok) p2_data = ldv;
        end
        e_busy = (clr_left > 0);
        @(posedge clk);
        #1;
        check_eq("busy_l1", {31'd0, busy1}, {31'd0, e_busy});
        check_eq("busy_l2", {31'd0, busy2}, {31'd0, e_busy});
        check_eq("valid_l1", {31'd0, vld1}, {31'd0, e_vld1});
        check_eq("valid_l2", {31'd0, vld2}, {31'd0, e_vld2});
        check_eq("misaligned_l1", {31'd0, mis1}, {31'd0, e_mis1});
        check_eq("misaligned_l2", {31'd0, mis2}, {31'd0, e_mis2});
        check_eq("rdata_l1", rd1, e_data1);
        check_eq("rdata_l2", rd2, e_data2);
        if (mem_known || rst) begin
            check_eq("dbg_l1", dbg1, e_dbg);
            check_eq("dbg_l2", dbg2, e_dbg);
        end
    endtask

    task automatic idle();
        rst = 0; wr = 0; rd = 0;
        tick();
    endtask

    task automatic store(input logic [6:0] a, input logic [1:0] s, input logic [31:0] d);
        rst = 0; wr = 1; rd = 0; addr = a; size = s; wdata = d;
        tick();
        wr = 0;
    endtask

    task automatic load_expect(input string tag, input logic [6:0] a, input logic [1:0] s,
                               input logic u, input logic [31:0] exp);
        rst = 0; wr = 0; rd = 1; addr = a; size = s; uns = u;
        tick();
        rd = 0;
        check_eq(tag, rd1, exp);
    endtask

    // Reset for one cycle, then count cycles with o_busy high (bounded).
    task automatic reset_and_count(input string tag);
        int n;
        rst = 1; wr = 0; rd = 0;
        tick();
        rst = 0;
        n = busy1 ? 1 : 0;
        for (int i = 0; i < 100 && busy1; i++) begin
            tick();
            if (busy1) n++;
        end
        check_eq(tag, n, 32);
    endtask

    initial begin
        logic [5:0] seen1, seen2;
        rst = 1; wr = 0; rd = 0; size = 2'd2; uns = 0; addr = '0; wdata = '0; dbg_addr = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;

        // 1: clear length and cleared contents
        reset_and_count("t1_busy_cycles");
        load_expect("t1_word0", 7'd0, 2'd2, 1'b0, 32'h0000_0000);
        idle();

        // 2: extension
        store(7'd0, 2'd2, 32'h8081_F0FF);
        load_expect("t2_byte_s", 7'd0, 2'd0, 1'b0, 32'hFFFF_FFFF);
        load_expect("t2_byte_u", 7'd0, 2'd0, 1'b1, 32'h0000_00FF);
        load_expect("t2_half_s", 7'd2, 2'd1, 1'b0, 32'hFFFF_8081);
        load_expect("t2_half_u", 7'd2, 2'd1, 1'b1, 32'h0000_8081);
        idle();

        // 3: half store, misaligned store dropped, illegal size dropped
        store(7'd10, 2'd1, 32'h0000_1234);
        load_expect("t3_word8", 7'd8, 2'd2, 1'b0, 32'h1234_0000);
        store(7'd11, 2'd1, 32'h0000_AAAA);
        check_eq("t3_mis_store", {31'd0, mis1}, 32'd1);
        store(7'd8, 2'd3, 32'h5555_5555);
        check_eq("t3_mis_size", {31'd0, mis1}, 32'd1);
        load_expect("t3_word8_kept", 7'd8, 2'd2, 1'b0, 32'h1234_0000);
        idle(); idle();

        // 4: back-to-back word loads on both latencies
        seen1 = '0; seen2 = '0;
        rd = 1; wr = 0; size = 2'd2;
        for (int k = 0; k < 6; k++) begin
            rd   = (k < 4);
            addr = 7'(4 * k);
            tick();
            seen1[k] = vld1;
            seen2[k] = vld2;
        end
        rd = 0;
        check_eq("t4_valid_l1", {26'd0, seen1}, 32'h0000_000F);
        check_eq("t4_valid_l2", {26'd0, seen2}, 32'h0000_001E);

        // 5: read-after-write and both flags set
        store(7'd4, 2'd2, 32'hDEAD_BEEF);
        load_expect("t5_raw", 7'd4, 2'd2, 1'b0, 32'hDEAD_BEEF);
        rd = 1; wr = 1; addr = 7'd12; size = 2'd2; wdata = 32'h1122_3344;
        tick();
        check_eq("t5_both_no_valid", {31'd0, vld1}, 32'd0);
        rd = 0; wr = 0;
        idle();
        check_eq("t5_both_no_valid_l2", {31'd0, vld2}, 32'd0);
        load_expect("t5_both_stored", 7'd12, 2'd2, 1'b0, 32'h1122_3344);
        idle();

        // 6: debug read, then reset in the middle of clearing
        dbg_addr = 5'd1;
        idle();
        check_eq("t6_dbg_word1", dbg1, 32'hDEAD_BEEF);
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 9; i++) tick();
        reset_and_count("t6_busy_after_rereset");
        idle();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            wr       = ($urandom_range(0, 3) == 0);
            rd       = ($urandom_range(0, 2) != 0);
            size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns      = 1'($urandom_range(0, 1));
            wdata    = $urandom;
            dbg_addr = 5'($urandom_range(0, 31));
            addr     = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0 && size != 2'd3)
                addr = addr & ~(7'((1 << size) - 1));
            tick();
        end
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
